// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD row feeder and the line-buffer control.
// Holds the FSM encoding and the default frame geometry.
package ccd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_HBLANK   = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

    localparam int PIX_W_DEF    = 8;
    localparam int ROW_LEN_DEF  = 640;
    localparam int NUM_ROWS_DEF = 480;
    localparam int HBLANK_DEF   = 4;
    localparam int CNT_W_DEF    = 11;

endpackage

// File: rtl/ccd_rd_pipe.sv
// Two-stage read pipe: aligns FIFO data (one cycle after the pop)
// with the valid/sof/eol tags produced by that pop.
module ccd_rd_pipe #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             rd,
    input  logic             sof_tag,
    input  logic             eol_tag,
    input  logic [PIX_W-1:0] q,
    output logic             data_valid,
    output logic [PIX_W-1:0] pixel,
    output logic             sof,
    output logic             eol
);

    logic rd_d1;
    logic sof_d1;
    logic eol_d1;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rd_d1      <= 1'b0;
            sof_d1     <= 1'b0;
            eol_d1     <= 1'b0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            pixel      <= '0;
        end else begin
            rd_d1      <= rd;
            sof_d1     <= sof_tag;
            eol_d1     <= eol_tag;
            data_valid <= rd_d1;
            sof        <= rd_d1 & sof_d1;
            eol        <= rd_d1 & eol_d1;
            if (rd_d1)
                pixel <= q;
        end
    end

endmodule

// File: rtl/ccd_row_feeder.sv
// Frames FIFO pixels into rows with horizontal blanking and
// holds each new frame until the line buffer reports frame_end.
module ccd_row_feeder
    import ccd_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int ROW_LEN  = ROW_LEN_DEF,
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int HBLANK   = HBLANK_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             enable,
    input  logic             fifo_rdempty,
    input  logic [PIX_W-1:0] fifo_q,
    output logic             fifo_rdreq,
    input  logic             frame_end,
    output logic             data_valid,
    output logic [PIX_W-1:0] pixel_out,
    output logic             sof,
    output logic             eol,
    output logic             busy,
    output logic             underrun,
    output logic [7:0]       frame_cnt
);

    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] col, col_nx;
    logic [CNT_W-1:0] row, row_nx;
    logic [CNT_W-1:0] blank, blank_nx;
    logic             underrun_nx;
    logic [7:0]       frame_cnt_nx;
    logic             pop;
    logic             sof_tag;
    logic             eol_tag;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            blank     <= '0;
            underrun  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            row       <= row_nx;
            blank     <= blank_nx;
            underrun  <= underrun_nx;
            frame_cnt <= frame_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        col_nx       = col;
        row_nx       = row;
        blank_nx     = blank;
        underrun_nx  = underrun;
        frame_cnt_nx = frame_cnt;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nx    = ST_ACTIVE;
                    col_nx      = '0;
                    row_nx      = '0;
                    underrun_nx = 1'b0;
                end
            end
            ST_ACTIVE: begin
                pop = !fifo_rdempty;
                if (fifo_rdempty) begin
                    underrun_nx = 1'b1;
                end else if (col == COL_LAST) begin
                    col_nx   = '0;
                    blank_nx = '0;
                    state_nx = (row == ROW_LAST) ? ST_WAIT_END : ST_HBLANK;
                end else begin
                    col_nx = col + ONE;
                end
            end
            ST_HBLANK: begin
                if (blank == BLANK_LAST) begin
                    state_nx = ST_ACTIVE;
                    row_nx   = row + ONE;
                end else begin
                    blank_nx = blank + ONE;
                end
            end
            ST_WAIT_END: begin
                // frame_end outside this state is deliberately dropped
                if (frame_end) begin
                    frame_cnt_nx = frame_cnt + 8'd1;
                    if (enable) begin
                        state_nx    = ST_ACTIVE;
                        col_nx      = '0;
                        row_nx      = '0;
                        underrun_nx = 1'b0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign sof_tag    = pop && (row == '0) && (col == '0);
    assign eol_tag    = pop && (col == COL_LAST);
    assign fifo_rdreq = pop;
    assign busy       = (state != ST_IDLE);

    ccd_rd_pipe #(
        .PIX_W(PIX_W)
    ) u_rd_pipe (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .rd        (pop),
        .sof_tag   (sof_tag),
        .eol_tag   (eol_tag),
        .q         (fifo_q),
        .data_valid(data_valid),
        .pixel     (pixel_out),
        .sof       (sof),
        .eol       (eol)
    );

endmodule
